// File: rtl/ball_packet_sender_if.sv
// Byte-stream link between the ball packet sender and the I2C master byte engine.
// The master modport is the side that offers bytes; slave is the byte engine.
interface ball_packet_sender_if;
    logic [7:0] m_data;
    logic       m_start;
    logic       m_stop;
    logic       m_valid;
    logic       m_ready;
    logic       m_resp_valid;
    logic       m_nack;

    modport master (
        output m_data, m_start, m_stop, m_valid,
        input  m_ready, m_resp_valid, m_nack
    );

    modport slave (
        input  m_data, m_start, m_stop, m_valid,
        output m_ready, m_resp_valid, m_nack
    );
endinterface

// File: rtl/ball_packet_sender.sv
// Latches the outgoing ball state, writes it as an 8-byte I2C frame to the peer board,
// then runs the go_right handshake. Define BALL_SENDER_RETRY_EN to retry frames on NACK.
module ball_packet_sender #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         HS_TIMEOUT = 25_000_000,
    parameter int         MAX_RETRY  = 3
) (
    input  logic                        clk_25MHZ,
    input  logic                        reset,
    input  logic                        send_trigger,
    input  logic [9:0]                  ball_y,
    input  logic [7:0]                  ball_vy,
    input  logic [1:0]                  gravity_phase,
    input  logic [19:0]                 ball_speed,
    ball_packet_sender_if.master        i2c,
    output logic                        go_right_o,
    input  logic                        peer_responding,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam int TW = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_TOP = TW'(HS_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, PUSH, RESP, HS_HI, HS_LO, DONE, FAIL} state_t;

    state_t        state;
    logic [2:0]    idx;
    logic          trig_d;
    logic [TW-1:0] timer;
    logic [9:0]    sh_y;
    logic [7:0]    sh_vy;
    logic [1:0]    sh_phase;
    logic [19:0]   sh_speed;
    logic [7:0]    data_q;
    logic          start_q;
    logic          stop_q;
    logic          valid_q;
`ifdef BALL_SENDER_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    logic [RW-1:0] retry_cnt;
`endif

    assign i2c.m_data  = data_q;
    assign i2c.m_start = start_q;
    assign i2c.m_stop  = stop_q;
    assign i2c.m_valid = valid_q;

    // Byte 0 is constant, so it is safe to fetch while the shadow is being loaded.
    function automatic logic [7:0] frame_byte(input logic [2:0] i);
        case (i)
            3'd0:    frame_byte = {SLAVE_ADDR, 1'b0};
            3'd1:    frame_byte = {sh_y[9:8], 6'b0};
            3'd2:    frame_byte = sh_y[7:0];
            3'd3:    frame_byte = sh_vy;
            3'd4:    frame_byte = {6'b0, sh_phase};
            3'd5:    frame_byte = sh_speed[7:0];
            3'd6:    frame_byte = sh_speed[15:8];
            default: frame_byte = {4'b0, sh_speed[19:16]};
        endcase
    endfunction

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            trig_d     <= 1'b1;
            timer      <= '0;
            sh_y       <= '0;
            sh_vy      <= '0;
            sh_phase   <= '0;
            sh_speed   <= '0;
            data_q     <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            valid_q    <= 1'b0;
            go_right_o <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef BALL_SENDER_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            trig_d <= send_trigger;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_trigger && !trig_d) begin
                        sh_y     <= ball_y;
                        sh_vy    <= ball_vy;
                        sh_phase <= gravity_phase;
                        sh_speed <= ball_speed;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        idx      <= 3'd0;
                        data_q   <= frame_byte(3'd0);
                        start_q  <= 1'b1;
                        stop_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        state    <= PUSH;
`ifdef BALL_SENDER_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                PUSH: begin
                    if (i2c.m_ready) begin
                        valid_q <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (i2c.m_resp_valid) begin
                        if (i2c.m_nack) begin
`ifdef BALL_SENDER_RETRY_EN
                            if (retry_cnt < RW'(MAX_RETRY)) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                idx       <= 3'd0;
                                data_q    <= frame_byte(3'd0);
                                start_q   <= 1'b1;
                                stop_q    <= 1'b0;
                                valid_q   <= 1'b1;
                                state     <= PUSH;
                            end else begin
                                err   <= 1'b1;
                                state <= FAIL;
                            end
`else
                            err   <= 1'b1;
                            state <= FAIL;
`endif
                        end else if (idx == 3'd7) begin
                            go_right_o <= 1'b1;
                            timer      <= TIMER_TOP;
                            state      <= HS_HI;
                        end else begin
                            idx     <= idx + 3'd1;
                            data_q  <= frame_byte(idx + 3'd1);
                            start_q <= 1'b0;
                            stop_q  <= (idx == 3'd6);
                            valid_q <= 1'b1;
                            state   <= PUSH;
                        end
                    end
                end
                HS_HI: begin
                    if (peer_responding) begin
                        go_right_o <= 1'b0;
                        timer      <= TIMER_TOP;
                        state      <= HS_LO;
                    end else if (timer == '0) begin
                        go_right_o <= 1'b0;
                        err        <= 1'b1;
                        state      <= FAIL;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                HS_LO: begin
                    if (!peer_responding) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (timer == '0) begin
                        err   <= 1'b1;
                        state <= FAIL;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAIL: begin
                    go_right_o <= 1'b0;
                    valid_q    <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_packet_sender.sv
// Bench for ball_packet_sender: byte-engine and peer models, table plus random frames,
// NACK, handshake timeout, trigger-edge and mid-handshake reset sequences.
`timescale 1ns/1ps
module tb_ball_packet_sender;
    localparam int HS_TO = 100;

    typedef logic [7:0][7:0] frame_t;
    typedef struct packed {logic [7:0] d; logic s; logic p;} cap_t;
    typedef struct {
        logic [9:0]  y;
        logic [7:0]  vy;
        logic [1:0]  ph;
        logic [19:0] sp;
        int          bp;
        frame_t      exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send_trigger = 1'b0;
    logic        peer_responding = 1'b0;
    logic [9:0]  ball_y = '0;
    logic [7:0]  ball_vy = '0;
    logic [1:0]  gravity_phase = '0;
    logic [19:0] ball_speed = '0;
    logic        go_right_o, busy, done, err;

    ball_packet_sender_if bif ();

    ball_packet_sender #(.HS_TIMEOUT(HS_TO)) dut (
        .clk_25MHZ      (clk),
        .reset          (reset),
        .send_trigger   (send_trigger),
        .ball_y         (ball_y),
        .ball_vy        (ball_vy),
        .gravity_phase  (gravity_phase),
        .ball_speed     (ball_speed),
        .i2c            (bif),
        .go_right_o     (go_right_o),
        .peer_responding(peer_responding),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #20 clk = ~clk;

    int   checks = 0, errors = 0;
    cap_t cap_q[$];
    cap_t hold, cur;
    int   bp_cycles = 0, stall = 0, resp_cnt = 0;
    int   nack_byte = -1, nack_frames = 0, frames_seen = 0, byte_ix = 0;
    int   start_count = 0, done_count = 0, peer_cnt = 0;
    bit   nack_now = 0, go_seen = 0, peer_auto = 1;

    function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Frame contents straight from the wire-format rules, using byte arithmetic.
    function automatic frame_t model_frame(input logic [9:0] y, input logic [7:0] vy,
                                           input logic [1:0] ph, input logic [19:0] sp);
        frame_t f;
        int yi = int'(y), si = int'(sp);
        f[0] = 8'(8'h42 * 2);
        f[1] = 8'((yi / 256) * 64);
        f[2] = 8'(yi % 256);
        f[3] = vy;
        f[4] = 8'(ph);
        f[5] = 8'(si % 256);
        f[6] = 8'((si / 256) % 256);
        f[7] = 8'(si / 65536);
        return f;
    endfunction

    function automatic frame_t mk8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        frame_t f;
        f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3;
        f[4] = b4; f[5] = b5; f[6] = b6; f[7] = b7;
        return f;
    endfunction

    // I2C byte-engine model: optional backpressure, fixed response latency, scripted NACKs.
    always @(negedge clk) begin
        if (reset) begin
            resp_cnt = 0; stall = 0;
            bif.m_ready = 1'b0; bif.m_resp_valid = 1'b0; bif.m_nack = 1'b0;
        end else begin
            bif.m_resp_valid = 1'b0;
            bif.m_nack = 1'b0;
            if (go_right_o) go_seen = 1;
            if (done) done_count++;
            if (resp_cnt > 0) begin
                chk(!bif.m_valid, "valid_in_resp", 64'(bif.m_valid), 64'd0);
                bif.m_ready = 1'b0;
                resp_cnt--;
                if (resp_cnt == 0) begin
                    bif.m_resp_valid = 1'b1;
                    bif.m_nack = nack_now;
                end
            end else if (bif.m_valid) begin
                cur.d = bif.m_data; cur.s = bif.m_start; cur.p = bif.m_stop;
                if (stall == 0) hold = cur;
                else chk(cur == hold, "hold_stable", 64'(cur), 64'(hold));
                if (stall >= bp_cycles) begin
                    bif.m_ready = 1'b1;
                    cap_q.push_back(cur);
                    stall = 0;
                    resp_cnt = 3;
                    if (cur.s) begin byte_ix = 0; frames_seen++; start_count++; end
                    else byte_ix++;
                    nack_now = (byte_ix == nack_byte) && (frames_seen <= nack_frames);
                end else begin
                    bif.m_ready = 1'b0;
                    stall++;
                end
            end else begin
                bif.m_ready = 1'b0;
                stall = 0;
            end
        end
    end

    // Peer model: answers go_right after 4 cycles, releases 2 cycles after it drops.
    always @(negedge clk) begin
        if (reset || !peer_auto) begin
            peer_cnt = 0;
            peer_responding = 1'b0;
        end else if (!peer_responding && go_right_o) begin
            peer_cnt++;
            if (peer_cnt == 4) begin peer_responding = 1'b1; peer_cnt = 0; end
        end else if (peer_responding && !go_right_o) begin
            peer_cnt++;
            if (peer_cnt == 2) begin peer_responding = 1'b0; peer_cnt = 0; end
        end
    end

    task automatic set_ball(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] ph, input logic [19:0] sp);
        ball_y = y; ball_vy = vy; gravity_phase = ph; ball_speed = sp;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        while (busy && n < bound) begin @(negedge clk); n++; end
        chk(!busy, {tag, "_idle_timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] ph,
                             input logic [19:0] sp, input int bp, input frame_t exp, input string tag);
        int d0 = done_count;
        cap_q.delete();
        bp_cycles = bp;
        set_ball(y, vy, ph, sp);
        send_trigger = 1'b1;
        @(negedge clk);
        chk(busy == 1'b1, {tag, "_busy"}, 64'(busy), 64'd1);
        chk(err == 1'b0, {tag, "_err_cleared"}, 64'(err), 64'd0);
        set_ball(10'($urandom), 8'($urandom), 2'($urandom), 20'($urandom));
        wait_idle(3000, tag);
        send_trigger = 1'b0;
        @(negedge clk);
        chk(cap_q.size() == 8, {tag, "_nbytes"}, 64'(cap_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
            chk(cap_q[i].d == exp[i], $sformatf("%s_byte%0d", tag, i), 64'(cap_q[i].d), 64'(exp[i]));
            chk(cap_q[i].s == (i == 0) && cap_q[i].p == (i == 7), $sformatf("%s_flags%0d", tag, i),
                64'({cap_q[i].s, cap_q[i].p}), 64'({(i == 0), (i == 7)}));
        end
        chk(done_count - d0 == 1, {tag, "_done_pulses"}, 64'(done_count - d0), 64'd1);
        chk(err == 1'b0, {tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        vec_t vt[4];
        frame_t nom;
        int n, hi, s0, d0;
        logic [9:0] ry; logic [7:0] rvy; logic [1:0] rph; logic [19:0] rsp;

        bif.m_ready = 1'b0; bif.m_resp_valid = 1'b0; bif.m_nack = 1'b0;
        nom = mk8(8'h84, 8'h80, 8'hA5, 8'hFD, 8'h02, 8'hB0, 8'h1E, 8'h04);
        vt[0] = '{y: 10'h2A5, vy: 8'hFD, ph: 2'd2, sp: 20'h41EB0, bp: 0, exp: nom};
        vt[1] = '{y: 10'h2A5, vy: 8'hFD, ph: 2'd2, sp: 20'h41EB0, bp: 5, exp: nom};
        vt[2] = '{y: 10'h000, vy: 8'h00, ph: 2'd0, sp: 20'h00000, bp: 1,
                  exp: mk8(8'h84, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00)};
        vt[3] = '{y: 10'h3FF, vy: 8'h80, ph: 2'd3, sp: 20'hFFFFF, bp: 2,
                  exp: mk8(8'h84, 8'hC0, 8'hFF, 8'h80, 8'h03, 8'hFF, 8'hFF, 8'h0F)};

        repeat (3) @(negedge clk);
        chk(bif.m_valid == 0 && bif.m_start == 0 && bif.m_stop == 0, "rst_bus_flags",
            64'({bif.m_valid, bif.m_start, bif.m_stop}), 64'd0);
        chk(bif.m_data == 8'h00, "rst_m_data", 64'(bif.m_data), 64'd0);
        chk(go_right_o == 0, "rst_go_right", 64'(go_right_o), 64'd0);
        chk(busy == 0 && done == 0 && err == 0, "rst_status", 64'({busy, done, err}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vt[i]) run_frame(vt[i].y, vt[i].vy, vt[i].ph, vt[i].sp, vt[i].bp, vt[i].exp, $sformatf("vec%0d", i));

        for (int k = 0; k < 8; k++) begin
            ry = 10'($urandom); rvy = 8'($urandom); rph = 2'($urandom); rsp = 20'($urandom);
            run_frame(ry, rvy, rph, rsp, int'($urandom_range(0, 3)), model_frame(ry, rvy, rph, rsp), $sformatf("rnd%0d", k));
        end

`ifndef BALL_SENDER_RETRY_EN
        // NACK on byte 3 aborts the frame with no retry.
        nack_byte = 3; nack_frames = 1; frames_seen = 0; cap_q.delete(); go_seen = 0; bp_cycles = 0;
        set_ball(10'h2A5, 8'hFD, 2'd2, 20'h41EB0);
        send_trigger = 1'b1;
        @(negedge clk);
        n = 0;
        while (!err && n < 500) begin @(negedge clk); n++; end
        chk(err == 1'b1, "nack_err", 64'(err), 64'd1);
        @(negedge clk);
        chk(busy == 1'b0, "nack_busy_low", 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        chk(cap_q.size() == 4, "nack_nbytes", 64'(cap_q.size()), 64'd4);
        chk(go_seen == 1'b0, "nack_no_go_right", 64'(go_seen), 64'd0);
        chk(err == 1'b1, "nack_err_sticky", 64'(err), 64'd1);
        nack_byte = -1;
        send_trigger = 1'b0;
        @(negedge clk);
`else
        // Four NACKed frames exhaust the retries; two NACKs then an ACK completes.
        nack_byte = 3; nack_frames = 4; frames_seen = 0; bp_cycles = 0;
        s0 = start_count;
        set_ball(10'h2A5, 8'hFD, 2'd2, 20'h41EB0);
        send_trigger = 1'b1;
        @(negedge clk);
        wait_idle(3000, "retry4");
        chk(start_count - s0 == 4, "retry4_starts", 64'(start_count - s0), 64'd4);
        chk(err == 1'b1, "retry4_err", 64'(err), 64'd1);
        send_trigger = 1'b0;
        @(negedge clk);
        nack_frames = 2; frames_seen = 0;
        s0 = start_count; d0 = done_count;
        send_trigger = 1'b1;
        @(negedge clk);
        wait_idle(3000, "retry2");
        chk(start_count - s0 == 3, "retry2_starts", 64'(start_count - s0), 64'd3);
        chk(done_count - d0 == 1, "retry2_done", 64'(done_count - d0), 64'd1);
        chk(err == 1'b0, "retry2_err", 64'(err), 64'd0);
        nack_byte = -1;
        send_trigger = 1'b0;
        @(negedge clk);
`endif

        // Handshake timeout: peer never answers.
        peer_auto = 0; bp_cycles = 0;
        send_trigger = 1'b1;
        @(negedge clk);
        n = 0; hi = 0;
        while (busy && n < 2000) begin
            if (go_right_o) hi++;
            @(negedge clk);
            n++;
        end
        chk(hi == HS_TO, "hs_timeout_high_cycles", 64'(hi), 64'(HS_TO));
        chk(err == 1'b1 && busy == 1'b0, "hs_timeout_err_idle", 64'({err, busy}), 64'b10);
        send_trigger = 1'b0;
        peer_auto = 1;
        @(negedge clk);

        // Trigger held high and retoggled mid-frame: exactly one frame.
        cap_q.delete(); s0 = start_count; d0 = done_count;
        set_ball(10'h2A5, 8'hFD, 2'd2, 20'h41EB0);
        send_trigger = 1'b1;
        repeat (3) @(negedge clk);
        send_trigger = 1'b0;
        @(negedge clk);
        send_trigger = 1'b1;
        repeat (1000) @(negedge clk);
        chk(start_count - s0 == 1, "held_trig_starts", 64'(start_count - s0), 64'd1);
        chk(done_count - d0 == 1, "held_trig_done", 64'(done_count - d0), 64'd1);
        chk(cap_q.size() == 8 && busy == 0, "held_trig_bytes", 64'(cap_q.size()), 64'd8);
        send_trigger = 1'b0;
        @(negedge clk);
        run_frame(vt[3].y, vt[3].vy, vt[3].ph, vt[3].sp, 0, vt[3].exp, "second_edge");

        // Reset while go_right_o is high.
        peer_auto = 0;
        s0 = start_count;
        send_trigger = 1'b1;
        n = 0;
        while (!go_right_o && n < 500) begin @(negedge clk); n++; end
        chk(go_right_o == 1'b1, "rst_hs_reached", 64'(go_right_o), 64'd1);
        #5 reset = 1'b1;
        #1;
        chk(go_right_o == 0 && busy == 0 && bif.m_valid == 0, "rst_hs_outputs",
            64'({go_right_o, busy, bif.m_valid}), 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        peer_auto = 1;
        s0 = start_count;
        repeat (30) @(negedge clk);
        chk(start_count == s0 && busy == 0, "rst_held_trig_no_frame", 64'(start_count - s0), 64'd0);
        send_trigger = 1'b0;
        @(negedge clk);
        run_frame(vt[0].y, vt[0].vy, vt[0].ph, vt[0].sp, 0, vt[0].exp, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
